pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock supervisor for the iCE40 PLL that turns the 12 MHz board clock into the 24 MHz pixel/stream clock. It runs on the 12 MHz input clock, because the PLL output is not trustworthy until lock. It holds the PLL in reset at power-up and waits for lock with a timeout and bounded retries. It declares the generated clock usable only after lock has been continuously stable, and falls back to bypass when the PLL never locks.

## Interface
Parameters:
- RESET_CYCLES, 16: number of clock cycles pll_resetb is held low per attempt (≥1).
- LOCK_TIMEOUT, 1200: cycles allowed in WAIT_LOCK before an attempt fails (100 µs at 12 MHz).
- STABLE_CYCLES, 120: cycles synchronized lock must stay high before ready.
- MAX_RETRIES, 3: extra attempts after the first before entering FAIL.

Ports:
- clock  in  1  12 MHz board clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK output; asynchronous to clock.
- restart  in  1  synchronous pulse; restarts the sequence from RESET_HOLD.
- pll_resetb  out  1  drives the PLL RESETB pin (0 = PLL held in reset).
- pll_bypass  out  1  drives the PLL BYPASS pin.
- ready  out  1  generated clock is locked and stable.
- fail  out  1  all attempts exhausted; PLL is in bypass.
- retry_count  out  2  attempts failed in the current sequence.
- lost_count  out  8  lock losses seen while in RUN; saturates at 255.
- state  out  3  current state, for debug: RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation
- pll_lock passes through a 2-flop synchronizer (lock_s) before any use. Both flops reset to 0.
- Each attempt starts in RESET_HOLD:
  - pll_resetb=0.
  - The counter runs 0..RESET_CYCLES-1, then the FSM moves to WAIT_LOCK with the counter cleared.
- WAIT_LOCK (pll_resetb=1):
  - lock_s=1 → STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0, and retry_count<MAX_RETRIES → retry_count+1, then RESET_HOLD.
  - Same timeout with retry_count==MAX_RETRIES → FAIL.
- STABLE (pll_resetb=1):
  - lock_s=0 → WAIT_LOCK. The counter is cleared, the timeout restarts, and retry_count does not change.
  - lock_s high for STABLE_CYCLES consecutive cycles → RUN.
- RUN: ready=1.
  - lock_s=0 → RESET_HOLD. lost_count+1 (saturating at 255) and retry_count cleared.
- FAIL: pll_resetb=0, pll_bypass=1, fail=1.
  - The FSM stays in FAIL until restart or reset_n.
- restart=1 in any state → RESET_HOLD next cycle, with counter and retry_count cleared and fail/bypass cleared.
  - restart has priority over every lock or timeout event in the same cycle.
  - restart does not clear lost_count; only reset_n does.
- All outputs are registered and decoded from the registered next state, so they change together with state.
- Counter width is sized for the largest of RESET_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. There is no wrap-around in normal operation.

## Timing
- Reset values:
  - state=RESET_HOLD, pll_resetb=0, pll_bypass=0, ready=0, fail=0.
  - retry_count=0, lost_count=0, counter=0, synchronizer=0.
- After reset_n deasserts, pll_resetb is low for exactly RESET_CYCLES clock edges, then rises.
- Lock detect latency: 2 cycles (synchronizer) plus 1 cycle (state register).
  - pll_lock rising → state=STABLE 3 edges later.
- ready rises STABLE_CYCLES cycles after STABLE is entered.
- ready falls on the edge after lock_s=0 is sampled, i.e. 3 edges after pll_lock falls.
  - pll_resetb falls on that same edge.
- A one-cycle lock glitch is filtered only if it is shorter than one clock period. Any glitch that reaches lock_s is treated as real.
- Timeout and lock in the same cycle: lock wins (→ STABLE).
- reset_n asserted mid-sequence forces all reset values immediately, asynchronously. Deassertion restarts from RESET_HOLD.

## Test plan
Test parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

- Normal bring-up: release reset, raise pll_lock at cycle 10 and hold it → pll_resetb rises after 4 cycles, state=STABLE 3 cycles after lock, ready=1 after 8 more cycles, retry_count=0.
- Never lock: hold pll_lock=0 → three 24-cycle attempts (4 hold + 20 wait), retry_count goes 1, 2, then FAIL with pll_bypass=1, fail=1, pll_resetb=0, ready=0.
- Unstable lock: lock high 5 cycles, low 1, then high for good → STABLE→WAIT_LOCK with no retry increment, then ready after 8 stable cycles.
- Lock loss in RUN: drop pll_lock for 3 cycles while ready=1 → ready=0 and pll_resetb=0 3 edges later, lost_count=1, then full re-lock. Repeat 300 times → lost_count saturates at 255.
- Restart: pulse restart while in FAIL, and again in the same cycle as a WAIT_LOCK timeout → RESET_HOLD next cycle, fail=0, pll_bypass=0, retry_count=0, lost_count unchanged.
- Async reset mid-STABLE: assert reset_n for a half cycle → all outputs at reset values immediately; the sequence restarts cleanly.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor running on the 12 MHz board clock.
// Holds PLL in reset, waits for stable lock, retries, falls back to bypass.
module pll_lock_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 1200,
   parameter int STABLE_CYCLES = 120,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_resetb,
   output logic       pll_bypass,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_count,
   output logic [7:0] lost_count,
   output logic [2:0] state
);

   localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ?
                           RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ?
                           MAX_AB : STABLE_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [2:0] RESET_HOLD = 3'd0;
   localparam logic [2:0] WAIT_LOCK  = 3'd1;
   localparam logic [2:0] STABLE     = 3'd2;
   localparam logic [2:0] RUN        = 3'd3;
   localparam logic [2:0] FAIL       = 3'd4;

   localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

   logic          lock_m;
   logic          lock_s;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [2:0]    state_n;
   logic [1:0]    retry_n;
   logic [7:0]    lost_n;

   // pll_lock is asynchronous to clock
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      retry_n = retry_count;
      lost_n  = lost_count;
      unique case (state)
         RESET_HOLD: begin
            if (cnt == RST_LAST) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = STABLE;
               cnt_n   = '0;
            end else if (cnt == TO_LAST) begin
               cnt_n = '0;
               if (retry_count < RETRY_MAX) begin
                  retry_n = retry_count + 1'b1;
                  state_n = RESET_HOLD;
               end else begin
                  state_n = FAIL;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == ST_LAST) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_n = RESET_HOLD;
               cnt_n   = '0;
               retry_n = '0;
               if (lost_count != 8'hff) begin
                  lost_n = lost_count + 8'd1;
               end
            end
         end
         FAIL: begin
            state_n = FAIL;
         end
         default: begin
            state_n = RESET_HOLD;
            cnt_n   = '0;
         end
      endcase
      // restart overrides any lock or timeout event this cycle
      if (restart) begin
         state_n = RESET_HOLD;
         cnt_n   = '0;
         retry_n = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RESET_HOLD;
         cnt         <= '0;
         retry_count <= '0;
         lost_count  <= '0;
         pll_resetb  <= 1'b0;
         pll_bypass  <= 1'b0;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         retry_count <= retry_n;
         lost_count  <= lost_n;
         pll_resetb  <= (state_n == WAIT_LOCK) ||
                        (state_n == STABLE) ||
                        (state_n == RUN);
         pll_bypass  <= (state_n == FAIL);
         ready       <= (state_n == RUN);
         fail        <= (state_n == FAIL);
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a cycle-stamped
// expectation queue checked by a monitor process.
module tb_pll_lock_sequencer;

   localparam int DC = -1;

   logic       clock;
   logic       reset_n;
   logic       pll_lock;
   logic       restart;
   logic       pll_resetb;
   logic       pll_bypass;
   logic       ready;
   logic       fail;
   logic [1:0] retry_count;
   logic [7:0] lost_count;
   logic [2:0] state;

   typedef struct {
      string tag;
      int    cyc;
      int    st;
      int    rb;
      int    byp;
      int    rdy;
      int    fl;
      int    rc;
      int    lc;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   pll_lock_sequencer #(
      .RESET_CYCLES (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .pll_resetb (pll_resetb),
      .pll_bypass (pll_bypass),
      .ready      (ready),
      .fail       (fail),
      .retry_count(retry_count),
      .lost_count (lost_count),
      .state      (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input int exp);
      if (exp < 0) return;
      tests++;
      assert (obs === 32'(exp)) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_now(input string tag, input int st,
                            input int rb, input int byp, input int rdy,
                            input int fl, input int rc, input int lc);
      chk({tag, ".state"}, 32'(state), st);
      chk({tag, ".pll_resetb"}, 32'(pll_resetb), rb);
      chk({tag, ".pll_bypass"}, 32'(pll_bypass), byp);
      chk({tag, ".ready"}, 32'(ready), rdy);
      chk({tag, ".fail"}, 32'(fail), fl);
      chk({tag, ".retry_count"}, 32'(retry_count), rc);
      chk({tag, ".lost_count"}, 32'(lost_count), lc);
   endtask

   task automatic expect_at(input string tag, input int d, input int st,
                            input int rb, input int byp, input int rdy,
                            input int fl, input int rc, input int lc);
      exp_t e;
      e.tag = tag;
      e.cyc = cyc + d;
      e.st  = st;
      e.rb  = rb;
      e.byp = byp;
      e.rdy = rdy;
      e.fl  = fl;
      e.rc  = rc;
      e.lc  = lc;
      q.push_back(e);
   endtask

   // Monitor: compares queued expectations on their stamped cycle
   initial begin
      forever begin
         @(posedge clock);
         cyc++;
         #2;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
               check_now(q[i].tag, q[i].st, q[i].rb, q[i].byp,
                         q[i].rdy, q[i].fl, q[i].rc, q[i].lc);
               q.delete(i);
            end else if (q[i].cyc < cyc) begin
               tests++;
               fails++;
               $error("FAIL %s stale expectation cycle=%0d now=%0d",
                      q[i].tag, q[i].cyc, cyc);
               q.delete(i);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clock);
         n++;
      end
      #3;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $error("FAIL drain pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int lc;
      int prev;
      reset_n  = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      check_now("reset", 0, 0, 0, 0, 0, 0, 0);
      wait_cyc(3);
      reset_n = 1'b1;

      // normal bring-up
      expect_at("up_hold", 3, 0, 0, 0, 0, 0, 0, 0);
      expect_at("up_wait", 4, 1, 1, 0, 0, 0, 0, 0);
      wait_cyc(10);
      pll_lock = 1'b1;
      expect_at("up_sync", 2, 1, 1, 0, 0, 0, 0, 0);
      expect_at("up_stable", 3, 2, 1, 0, 0, 0, 0, 0);
      expect_at("up_stable_last", 10, 2, 1, 0, 0, 0, 0, 0);
      expect_at("up_ready", 11, 3, 1, 0, 1, 0, 0, 0);
      wait_cyc(11);

      // repeated lock loss in RUN
      for (int i = 0; i < 300; i++) begin
         lc   = (i + 1 > 255) ? 255 : i + 1;
         prev = (i > 255) ? 255 : i;
         pll_lock = 1'b0;
         expect_at("loss_run", 2, 3, 1, 0, 1, 0, 0, prev);
         expect_at("loss_drop", 3, 0, 0, 0, 0, 0, 0, lc);
         expect_at("relock_wait", 7, 1, 1, 0, 0, 0, 0, lc);
         expect_at("relock_stable", 8, 2, 1, 0, 0, 0, 0, lc);
         expect_at("relock_ready", 16, 3, 1, 0, 1, 0, 0, lc);
         wait_cyc(3);
         pll_lock = 1'b1;
         wait_cyc(14);
      end
      expect_at("lost_sat", 0, 3, 1, 0, 1, 0, 0, 255);
      drain();
      #1;

      // restart out of RUN, then never lock
      restart  = 1'b1;
      pll_lock = 1'b0;
      wait_cyc(1);
      restart = 1'b0;
      expect_at("rs_run", 0, 0, 0, 0, 0, 0, 0, 255);
      expect_at("nl_w1_end", 23, 1, 1, 0, 0, 0, 0, 255);
      expect_at("nl_retry1", 24, 0, 0, 0, 0, 0, 1, 255);
      expect_at("nl_w2_end", 47, 1, 1, 0, 0, 0, 1, 255);
      expect_at("nl_retry2", 48, 0, 0, 0, 0, 0, 2, 255);
      expect_at("nl_w3_end", 71, 1, 1, 0, 0, 0, 2, 255);
      expect_at("nl_fail", 72, 4, 0, 1, 0, 1, DC, 255);
      expect_at("nl_fail_hold", 80, 4, 0, 1, 0, 1, DC, 255);
      wait_cyc(80);

      // restart in FAIL, then restart on a timeout cycle
      restart = 1'b1;
      wait_cyc(1);
      restart = 1'b0;
      expect_at("rs_fail", 0, 0, 0, 0, 0, 0, 0, 255);
      expect_at("to_w_end", 23, 1, 1, 0, 0, 0, 0, 255);
      wait_cyc(23);
      restart = 1'b1;
      wait_cyc(1);
      restart = 1'b0;
      expect_at("rs_timeout", 0, 0, 0, 0, 0, 0, 0, 255);
      expect_at("rt_w_end", 23, 1, 1, 0, 0, 0, 0, 255);
      expect_at("rt_retry1", 24, 0, 0, 0, 0, 0, 1, 255);
      wait_cyc(24);

      // async reset while in STABLE
      pll_lock = 1'b1;
      expect_at("pre_ar_stable", 5, 2, 1, 0, 0, 0, 1, 255);
      wait_cyc(6);
      drain();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_now("async_reset", 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      expect_at("ar_hold", 3, 0, 0, 0, 0, 0, 0, 0);
      expect_at("ar_wait", 4, 1, 1, 0, 0, 0, 0, 0);
      expect_at("ar_stable", 5, 2, 1, 0, 0, 0, 0, 0);
      expect_at("ar_stable_last", 12, 2, 1, 0, 0, 0, 0, 0);
      expect_at("ar_ready", 13, 3, 1, 0, 1, 0, 0, 0);
      wait_cyc(13);
      drain();
      #1;

      // unstable lock: one low cycle while in STABLE
      pll_lock = 1'b0;
      reset_n  = 1'b0;
      wait_cyc(2);
      reset_n = 1'b1;
      wait_cyc(5);
      pll_lock = 1'b1;
      expect_at("us_stable", 3, 2, 1, 0, 0, 0, 0, 0);
      expect_at("us_still", 7, 2, 1, 0, 0, 0, 0, 0);
      expect_at("us_drop", 8, 1, 1, 0, 0, 0, 0, 0);
      expect_at("us_restable", 9, 2, 1, 0, 0, 0, 0, 0);
      expect_at("us_pre", 16, 2, 1, 0, 0, 0, 0, 0);
      expect_at("us_ready", 17, 3, 1, 0, 1, 0, 0, 0);
      wait_cyc(5);
      pll_lock = 1'b0;
      wait_cyc(1);
      pll_lock = 1'b1;
      wait_cyc(12);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
